rcu: RTL and testbench
======================

# rcu

Receiver control unit for the USB full-speed receive path. It sequences the receiver datapath, which comprises the edge detector, bit timer, shift register, EOP detector and RX FIFO. It detects packet start and validates the sync byte, then commands a FIFO write for each received data byte. It also flags sync, bit-stuff-boundary and EOP-alignment errors, and reports when a packet is in progress.

## Interface
Parameters:
- SYNC_BYTE, 8'h80, expected contents of rcv_data after the first byte (LSB-first shift, so the newest bit is in the MSB)

Ports:
- clk  input  1  system clock, all state on rising edge
- n_rst  input  1  asynchronous, active-low reset
- d_edge  input  1  one-cycle pulse on any transition of synchronized d_plus
- eop  input  1  level from the EOP detector, high while d_plus and d_minus are both low
- shift_enable  input  1  one-cycle pulse at each bit sample point
- byte_received  input  1  one-cycle pulse from the bit timer, the cycle after the 8th shift_enable of a byte
- rcv_data  input  8  current shift-register contents
- rcving  output  1  high from packet start until the line returns to idle
- w_enable  output  1  one-cycle FIFO write strobe
- r_error  output  1  sticky receive-error flag

## Operation
The block is a Moore FSM with states IDLE, SYNC_WAIT, SYNC_CHK, RX, STORE, EOP_WAIT, ERR_WAIT and ERR_EOP.

It keeps a 3-bit bit_cnt:
- cleared in IDLE;
- incremented on every shift_enable in every other state;
- wraps from 7 to 0.

State behaviour and transitions:
- IDLE: rcving=0, w_enable=0.
  - On d_edge, go to SYNC_WAIT and clear r_error.
- SYNC_WAIT: rcving=1.
  - If shift_enable && eop, go to ERR_WAIT (premature EOP) and set r_error.
  - Else if byte_received, go to SYNC_CHK.
- SYNC_CHK: one cycle.
  - If rcv_data==SYNC_BYTE, go to RX.
  - Otherwise set r_error and go to ERR_WAIT.
- RX: rcving=1.
  - If shift_enable && eop:
    - bit_cnt==0 (byte-aligned) goes to EOP_WAIT;
    - otherwise set r_error and go to ERR_EOP.
  - Else if byte_received, go to STORE.
- STORE: w_enable=1 for exactly one cycle, then go to RX.
- EOP_WAIT: rcving=1.
  - On d_edge (line returns to J/idle), go to IDLE.
- ERR_WAIT: rcving=1, discards bits.
  - On shift_enable && eop, go to ERR_EOP.
- ERR_EOP: rcving=1.
  - On d_edge, go to IDLE.

Precedence and flag rules:
- In RX and SYNC_WAIT, an EOP sampled with shift_enable has priority over byte_received in the same cycle.
- r_error is set on entry to any error path. It holds through IDLE and clears only on the d_edge that starts the next packet.
- w_enable is never asserted for the sync byte, nor after any error in the same packet.
- No data byte is written once EOP is detected.

## Timing
- Reset (n_rst low, asynchronous):
  - state goes to IDLE and bit_cnt to 0;
  - rcving=0, w_enable=0, r_error=0, effective immediately and not waiting for clk.
- Outputs are registered from state. They change on the clk edge following the causing input.
- d_edge in IDLE causes rcving=1 on the next rising edge, a latency of 1 cycle.
- byte_received in RX causes w_enable high one cycle later, for exactly one cycle. The earliest next w_enable is 8 bit times later.
- For the sync check, byte_received is followed by the SYNC_CHK cycle, then RX. r_error on a bad sync is visible 2 cycles after byte_received.
- After a valid EOP, rcving falls 1 cycle after the d_edge in EOP_WAIT.
- Reset asserted mid-packet aborts without a FIFO write. The block restarts from IDLE when n_rst releases.

## Test plan
- Reset during RX: assert n_rst=0 asynchronously -> rcving, w_enable and r_error are 0 before the next clk edge, and the FSM returns to IDLE.
- Valid packet: sync 8'h80, then data bytes 8'hA5 and 8'h3C, then EOP on a byte boundary, then d_edge -> w_enable pulses exactly twice, each one cycle after byte_received. rcving falls 1 cycle after the closing d_edge, and r_error stays 0.
- Bad sync: rcv_data=8'h81 at the first byte_received -> r_error=1 two cycles later, no w_enable for the whole packet, and rcving stays 1 until EOP plus d_edge.
- Misaligned EOP: EOP sampled after 3 data bits (bit_cnt=3) -> r_error=1, no extra w_enable, then return to IDLE on d_edge.
- Sticky error: following a bad-sync packet, a valid packet -> r_error clears on its starting d_edge and remains 0 throughout.
- Premature EOP: EOP sampled during SYNC_WAIT -> r_error=1 and no w_enable.

Source files
------------

// File: rtl/rcu_if.sv
// Receive-path handshake between the USB RX datapath (edge detector, bit timer,
// shift register, EOP detector) and the receiver control unit.
interface rcu_if;
  logic       d_edge;
  logic       eop;
  logic       shift_enable;
  logic       byte_received;
  logic [7:0] rcv_data;
  logic       rcving;
  logic       w_enable;
  logic       r_error;

  modport master (
    output d_edge, eop, shift_enable, byte_received, rcv_data,
    input  rcving, w_enable, r_error
  );

  modport slave (
    input  d_edge, eop, shift_enable, byte_received, rcv_data,
    output rcving, w_enable, r_error
  );
endinterface

// File: rtl/rcu.sv
// USB full-speed receiver control unit: detects packet start, validates sync,
// strobes FIFO writes per data byte and flags sync/EOP-alignment errors.
module rcu #(
  parameter logic [7:0] SYNC_BYTE = 8'h80
) (
  input  logic clk,
  input  logic n_rst,
  rcu_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    SYNC_WAIT,
    SYNC_CHK,
    RX,
    STORE,
    EOP_WAIT,
    ERR_WAIT,
    ERR_EOP
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       r_error_q, r_error_d;
  logic       rcving_q;
  logic       w_enable_q;
  logic       eop_sample;

  assign eop_sample = bus.shift_enable && bus.eop;

  always_comb begin
    state_d   = state_q;
    r_error_d = r_error_q;
    unique case (state_q)
      IDLE: begin
        if (bus.d_edge) begin
          state_d   = SYNC_WAIT;
          r_error_d = 1'b0;
        end
      end
      SYNC_WAIT: begin
        if (eop_sample) begin
          state_d   = ERR_WAIT;
          r_error_d = 1'b1;
        end else if (bus.byte_received) begin
          state_d = SYNC_CHK;
        end
      end
      SYNC_CHK: begin
        if (bus.rcv_data == SYNC_BYTE) begin
          state_d = RX;
        end else begin
          state_d   = ERR_WAIT;
          r_error_d = 1'b1;
        end
      end
      RX: begin
        // EOP outranks a coincident byte_received so no byte is written after EOP
        if (eop_sample) begin
          if (bit_cnt_q == 3'd0) begin
            state_d = EOP_WAIT;
          end else begin
            state_d   = ERR_EOP;
            r_error_d = 1'b1;
          end
        end else if (bus.byte_received) begin
          state_d = STORE;
        end
      end
      STORE: begin
        state_d = RX;
      end
      EOP_WAIT: begin
        if (bus.d_edge) state_d = IDLE;
      end
      ERR_WAIT: begin
        if (eop_sample) state_d = ERR_EOP;
      end
      ERR_EOP: begin
        if (bus.d_edge) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    if (state_q == IDLE) begin
      bit_cnt_d = 3'd0;
    end else if (bus.shift_enable) begin
      bit_cnt_d = bit_cnt_q + 3'd1;
    end
  end

  // Outputs are decoded from the next state so they land on the same edge as the state.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= 3'd0;
      r_error_q  <= 1'b0;
      rcving_q   <= 1'b0;
      w_enable_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      r_error_q  <= r_error_d;
      rcving_q   <= (state_d != IDLE);
      w_enable_q <= (state_d == STORE);
    end
  end

  assign bus.rcving   = rcving_q;
  assign bus.w_enable = w_enable_q;
  assign bus.r_error  = r_error_q;

endmodule

// File: tb/tb_rcu.sv
// Bench for rcu: packets are built as cycle timelines whose expected outputs
// come from packet-level rules (start, sync verdict, byte writes, EOP, close).
module tb_rcu;

  localparam int KVALID    = 0;
  localparam int KBADSYNC  = 1;
  localparam int KPREMAT   = 2;
  localparam int KMISALIGN = 3;

  typedef struct {
    logic       de;
    logic       se;
    logic       ep;
    logic       br;
    logic [7:0] data;
    logic       expRcv;
    logic       expW;
    logic       expErr;
  } cycle_t;

  logic clk;
  logic n_rst;

  rcu_if bus ();

  rcu #(.SYNC_BYTE(8'h80)) dut (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         errors = 0;
  int         checks = 0;
  cycle_t     timeline[$];
  logic [7:0] dataQ[$];
  logic [7:0] sr = 8'h00;
  logic       mRcv = 1'b0;
  logic       mErr = 1'b0;

  task automatic checkOutput(input string tag, input logic observed, input logic expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input cycle_t c);
    bus.d_edge        = c.de;
    bus.shift_enable  = c.se;
    bus.eop           = c.ep;
    bus.byte_received = c.br;
    bus.rcv_data      = c.data;
  endtask

  task automatic pushCycle(input logic de, input logic se, input logic ep, input logic br, input logic w);
    cycle_t c;
    c.de     = de;
    c.se     = se;
    c.ep     = ep;
    c.br     = br;
    c.data   = sr;
    c.expRcv = mRcv;
    c.expW   = w;
    c.expErr = mErr;
    timeline.push_back(c);
  endtask

  // One bit time: sample pulse, then byte_received on the next cycle if the byte is complete
  task automatic sendBit(input logic b, input logic eopNow, input logic byteDone,
                         input logic writeOk, input logic badSync);
    pushCycle(1'b0, 1'b1, eopNow, 1'b0, 1'b0);
    if (!eopNow) sr = {b, sr[7:1]};
    pushCycle(1'b0, 1'b0, eopNow, byteDone, byteDone && writeOk);
    if (byteDone && badSync) mErr = 1'b1;
    for (int q = 0; q < 2; q++) begin
      pushCycle(!eopNow && ($urandom_range(0, 3) == 0), 1'b0, eopNow, 1'b0, 1'b0);
    end
  endtask

  task automatic buildPacket(input int kind, input logic [7:0] syncVal, input int extraBits);
    mErr = 1'b0;
    mRcv = 1'b1;
    pushCycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat ($urandom_range(0, 2)) pushCycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    if (kind == KPREMAT) begin
      for (int i = 0; i < extraBits; i++) sendBit(syncVal[i], 1'b0, 1'b0, 1'b0, 1'b0);
    end else begin
      for (int i = 0; i < 8; i++) sendBit(syncVal[i], 1'b0, i == 7, 1'b0, kind == KBADSYNC);
      foreach (dataQ[k]) begin
        for (int j = 0; j < 8; j++) sendBit(dataQ[k][j], 1'b0, j == 7, kind != KBADSYNC, 1'b0);
      end
      if (kind == KMISALIGN) begin
        for (int i = 0; i < extraBits; i++) sendBit(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, 1'b0);
      end
    end
    if (kind == KPREMAT || kind == KMISALIGN) mErr = 1'b1;
    sendBit(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    sendBit(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat ($urandom_range(0, 2)) pushCycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    mRcv = 1'b0;
    pushCycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat ($urandom_range(2, 5)) begin
      pushCycle(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'b0);
    end
  endtask

  task automatic playTimeline(input int upTo);
    for (int i = 0; i < upTo; i++) begin
      applyStimulus(timeline[i]);
      @(negedge clk);
      checkOutput("rcving", bus.rcving, timeline[i].expRcv);
      checkOutput("w_enable", bus.w_enable, timeline[i].expW);
      checkOutput("r_error", bus.r_error, timeline[i].expErr);
    end
  endtask

  task automatic runPacket(input int kind, input logic [7:0] syncVal, input int extraBits);
    timeline.delete();
    buildPacket(kind, syncVal, extraBits);
    playTimeline(timeline.size());
  endtask

  task automatic quietInputs();
    bus.d_edge        = 1'b0;
    bus.shift_enable  = 1'b0;
    bus.eop           = 1'b0;
    bus.byte_received = 1'b0;
    bus.rcv_data      = 8'h00;
  endtask

  // Asynchronous reset between edges; outputs must clear before any clock edge
  task automatic asyncReset(input string tag);
    #2 n_rst = 1'b0;
    #1;
    checkOutput({tag, "_rcving"}, bus.rcving, 1'b0);
    checkOutput({tag, "_w_enable"}, bus.w_enable, 1'b0);
    checkOutput({tag, "_r_error"}, bus.r_error, 1'b0);
    mErr = 1'b0;
    mRcv = 1'b0;
    quietInputs();
    @(negedge clk);
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int         idx;
    int         kind;
    logic [7:0] v;

    n_rst = 1'b1;
    quietInputs();
    #2 n_rst = 1'b0;
    #1;
    checkOutput("por_rcving", bus.rcving, 1'b0);
    checkOutput("por_w_enable", bus.w_enable, 1'b0);
    checkOutput("por_r_error", bus.r_error, 1'b0);
    @(negedge clk);
    @(negedge clk);
    n_rst = 1'b1;

    $display("[TB] valid packet A5 3C");
    dataQ = '{8'hA5, 8'h3C};
    runPacket(KVALID, 8'h80, 0);

    $display("[TB] bad sync 81");
    dataQ = '{8'h5A};
    runPacket(KBADSYNC, 8'h81, 0);

    $display("[TB] reset clears sticky error");
    asyncReset("rst_idle");

    $display("[TB] bad sync then valid packet");
    dataQ = '{8'hFF, 8'h00};
    runPacket(KBADSYNC, 8'h81, 0);
    dataQ = '{8'h3C};
    runPacket(KVALID, 8'h80, 0);

    $display("[TB] misaligned EOP after 3 data bits");
    dataQ = '{8'hC3};
    runPacket(KMISALIGN, 8'h80, 3);

    $display("[TB] premature EOP during sync");
    dataQ.delete();
    runPacket(KPREMAT, 8'h80, 4);

    $display("[TB] reset during RX while a write is strobed");
    dataQ = '{8'hA5, 8'h3C};
    timeline.delete();
    buildPacket(KVALID, 8'h80, 0);
    idx = 0;
    while (idx < timeline.size() && !timeline[idx].expW) idx++;
    playTimeline(idx + 1);
    asyncReset("rst_rx");
    timeline.delete();

    $display("[TB] randomized packets");
    for (int p = 0; p < 30; p++) begin
      kind = int'($urandom_range(0, 3));
      dataQ.delete();
      if (kind != KPREMAT) begin
        repeat ($urandom_range(0, 3)) dataQ.push_back(8'($urandom_range(0, 255)));
      end
      v = 8'($urandom_range(0, 255));
      if (v == 8'h80) v = 8'h81;
      runPacket(kind, (kind == KBADSYNC) ? v : 8'h80,
                (kind == KPREMAT) ? int'($urandom_range(0, 7)) : int'($urandom_range(1, 7)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
